// File: rtl/hist_pass_controller.sv
// Multi-channel histogram pass sequencer.
// Per channel: clear bin RAM, accumulate pass, drain wait, write pass.
// Every output decodes registered state/counters only; no input reaches an output combinationally.
module hist_pass_controller #(
   parameter int ADDR_W    = 16,
   parameter int NUM_PIX   = 65536,
   parameter int BIN_AW    = 8,
   parameter int NUM_BINS  = 256,
   parameter int NUM_CH    = 1,
   parameter int CH_W      = 2,
   parameter int DRAIN_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mem_ready,
   input  logic              abort,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [BIN_AW-1:0] bin_addr,
   output logic              rd_en,
   output logic              clr_we,
   output logic              we,
   output logic              enable,
   output logic [CH_W-1:0]   chan,
   output logic              busy,
   output logic              pass1_done,
   output logic              all_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   // Terminal compares (not carries) end each pass, so NUM_PIX = 2^ADDR_W works.
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIX - 1);
   localparam logic [BIN_AW-1:0] BIN_LAST = BIN_AW'(NUM_BINS - 1);
   localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
   localparam int                DW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   // DRAIN is never entered when DRAIN_CYC = 0, so the clamp only keeps the constant legal.
   localparam logic [DW-1:0]     DRN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

   state_t              state, state_n;
   logic [ADDR_W-1:0]   pix_n;
   logic [BIN_AW-1:0]   bin_n;
   logic [CH_W-1:0]     chan_n;
   logic [DW-1:0]       drn, drn_n;
   logic                p1, p1_n;

   // State and counter registers; reset and abort both land in a fully cleared IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pix_addr <= '0;
         bin_addr <= '0;
         chan     <= '0;
         drn      <= '0;
         p1       <= 1'b0;
      end else begin
         state    <= state_n;
         pix_addr <= pix_n;
         bin_addr <= bin_n;
         chan     <= chan_n;
         drn      <= drn_n;
         p1       <= p1_n;
      end
   end

   // Next-state and counter update; abort overrides everything below it.
   always_comb begin
      state_n = state;
      pix_n   = pix_addr;
      bin_n   = bin_addr;
      chan_n  = chan;
      drn_n   = drn;
      p1_n    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_CLEAR;
               chan_n  = '0;
               bin_n   = '0;
               pix_n   = '0;
            end
         end
         S_CLEAR: begin
            // Bin RAM is local, so clearing never waits on mem_ready.
            if (bin_addr == BIN_LAST) begin
               state_n = S_ACCUM;
               bin_n   = '0;
               pix_n   = '0;
            end else begin
               bin_n = bin_addr + BIN_AW'(1);
            end
         end
         S_ACCUM: begin
            if (mem_ready) begin
               if (pix_addr == PIX_LAST) begin
                  pix_n = '0;
                  drn_n = '0;
                  if (DRAIN_CYC == 0) begin
                     state_n = S_WRITE;
                     p1_n    = 1'b1;
                  end else begin
                     state_n = S_DRAIN;
                  end
               end else begin
                  pix_n = pix_addr + ADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drn == DRN_LAST) begin
               state_n = S_WRITE;
               p1_n    = 1'b1;
               drn_n   = '0;
            end else begin
               drn_n = drn + DW'(1);
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               if (pix_addr == PIX_LAST) begin
                  pix_n = '0;
                  if (chan == CH_LAST) begin
                     state_n = S_DONE;
                  end else begin
                     state_n = S_CLEAR;
                     chan_n  = chan + CH_W'(1);
                     bin_n   = '0;
                  end
               end else begin
                  pix_n = pix_addr + ADDR_W'(1);
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (abort) begin
         state_n = S_IDLE;
         pix_n   = '0;
         bin_n   = '0;
         chan_n  = '0;
         drn_n   = '0;
         p1_n    = 1'b0;
      end
   end

   // Moore output decode.
   always_comb begin
      rd_en      = (state == S_ACCUM) || (state == S_WRITE);
      clr_we     = (state == S_CLEAR);
      we         = (state == S_WRITE);
      enable     = (state == S_WRITE);
      busy       = (state != S_IDLE) && (state != S_DONE);
      pass1_done = p1;
      all_done   = (state == S_DONE);
   end

endmodule
